// File: rtl/acc_cpu.sv
// -----------------------------------------------------------------------------
// acc_cpu -- tiny 8-bit accumulator CPU with a 6502-flavoured instruction subset.
//
// One byte-wide memory port is shared by instruction fetch, operand fetch and
// data access. Memory answers combinationally: d_in reflects addr in the same
// cycle. Every instruction runs through a Moore state machine:
//   FETCH -> OP1 -> FETCH                 immediate (LDA/ADC/AND/ORA/EOR #)
//   FETCH -> IMPL -> FETCH                implied   (CLC/SEC/NOP)
//   FETCH -> OP1 -> OP2 -> FETCH          JMP abs
//   FETCH -> OP1 -> OP2 -> MEM -> FETCH   LDA abs / STA abs
// Any other opcode parks the machine in HALT until reset.
//
// Parameters
//   ADDR_W    address bus width, 9..16
//   RESET_PC  program counter value after reset
//
// Ports
//   clk    in   clock, all state changes on its rising edge
//   rst    in   asynchronous active-high reset
//   rdy    in   1 = advance, 0 = freeze the current cycle (we is forced low)
//   d_in   in   read data for addr, same cycle
//   addr   out  memory address
//   d_out  out  write data (always the accumulator, qualified by we)
//   we     out  write strobe, memory captures d_out at addr on the rising edge
//   sync   out  high in opcode-fetch cycles
//   halt   out  high after an undefined opcode was fetched
//   a_out  out  accumulator
//   p_out  out  status byte {N,V,1,0,0,0,Z,C}
// -----------------------------------------------------------------------------
module acc_cpu #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [7:0]        d_in,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        d_out,
    output logic              we,
    output logic              sync,
    output logic              halt,
    output logic [7:0]        a_out,
    output logic [7:0]        p_out
);

    // High address latch only needs the bits that reach the bus.
    localparam int unsigned HI_W = ADDR_W - 8;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_OP1,
        ST_OP2,
        ST_MEM,
        ST_IMPL,
        ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        CLS_IMM,
        CLS_ABS,
        CLS_IMPL,
        CLS_BAD
    } op_class_e;

    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_ADC_IMM = 8'h69;
    localparam logic [7:0] OP_AND_IMM = 8'h29;
    localparam logic [7:0] OP_ORA_IMM = 8'h09;
    localparam logic [7:0] OP_EOR_IMM = 8'h49;
    localparam logic [7:0] OP_LDA_ABS = 8'hAD;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;
    localparam logic [7:0] OP_CLC     = 8'h18;
    localparam logic [7:0] OP_SEC     = 8'h38;
    localparam logic [7:0] OP_NOP     = 8'hEA;

    function automatic op_class_e classify(input logic [7:0] op);
        case (op)
            OP_LDA_IMM, OP_ADC_IMM, OP_AND_IMM,
            OP_ORA_IMM, OP_EOR_IMM:             return CLS_IMM;
            OP_LDA_ABS, OP_STA_ABS, OP_JMP_ABS: return CLS_ABS;
            OP_CLC, OP_SEC, OP_NOP:             return CLS_IMPL;
            default:                            return CLS_BAD;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic [7:0]        a_q,     a_d;
    logic              c_q,     c_d;
    logic              z_q,     z_d;
    logic              v_q,     v_d;
    logic              n_q,     n_d;
    logic [7:0]        ir_q,    ir_d;   // opcode latch
    logic [7:0]        lo_q,    lo_d;   // absolute address, low byte
    logic [HI_W-1:0]   hi_q,    hi_d;   // absolute address, high bits

    logic [ADDR_W-1:0] pc_inc;
    logic [8:0]        sum9;
    logic              upd_nz;

    // Incrementing at full width gives the modulo-2^ADDR_W wrap for free.
    assign pc_inc = pc_q + ADDR_W'(1);

    // Carry-in is the current C flag; bit 8 of the sum becomes the new C.
    assign sum9 = {1'b0, a_q} + {1'b0, d_in} + {8'b0, c_q};

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable driven here gets a default at the top of the block;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        a_d     = a_q;
        c_d     = c_q;
        z_d     = z_q;
        v_d     = v_q;
        n_d     = n_q;
        ir_d    = ir_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        upd_nz  = 1'b0;

        // With rdy low nothing moves: all defaults above are hold values.
        if (rdy) begin
            case (state_q)
                ST_FETCH: begin
                    ir_d = d_in;
                    pc_d = pc_inc;
                    case (classify(d_in))
                        CLS_IMM:  state_d = ST_OP1;
                        CLS_ABS:  state_d = ST_OP1;
                        CLS_IMPL: state_d = ST_IMPL;
                        default:  state_d = ST_HALT;
                    endcase
                end

                ST_OP1: begin
                    pc_d = pc_inc;
                    if (classify(ir_q) == CLS_IMM) begin
                        upd_nz  = 1'b1;
                        state_d = ST_FETCH;
                        case (ir_q)
                            OP_LDA_IMM: a_d = d_in;
                            OP_ADC_IMM: begin
                                a_d = sum9[7:0];
                                c_d = sum9[8];
                                // Overflow: operands agree in sign, result does not.
                                v_d = (a_q[7] == d_in[7]) && (sum9[7] != a_q[7]);
                            end
                            OP_AND_IMM: a_d = a_q & d_in;
                            OP_ORA_IMM: a_d = a_q | d_in;
                            OP_EOR_IMM: a_d = a_q ^ d_in;
                            default:    a_d = a_q;
                        endcase
                    end else begin
                        lo_d    = d_in;
                        state_d = ST_OP2;
                    end
                end

                ST_OP2: begin
                    hi_d = d_in[HI_W-1:0];
                    if (ir_q == OP_JMP_ABS) begin
                        pc_d    = {d_in[HI_W-1:0], lo_q};
                        state_d = ST_FETCH;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = ST_MEM;
                    end
                end

                ST_MEM: begin
                    // The STA write itself is produced by the output decode.
                    if (ir_q == OP_LDA_ABS) begin
                        a_d    = d_in;
                        upd_nz = 1'b1;
                    end
                    state_d = ST_FETCH;
                end

                ST_IMPL: begin
                    if (ir_q == OP_CLC) begin
                        c_d = 1'b0;
                    end else if (ir_q == OP_SEC) begin
                        c_d = 1'b1;
                    end
                    state_d = ST_FETCH;
                end

                ST_HALT: state_d = ST_HALT;

                default: state_d = ST_FETCH;
            endcase
        end

        if (upd_nz) begin
            z_d = (a_d == 8'h00);
            n_d = a_d[7];
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            a_q     <= 8'h00;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
            ir_q    <= 8'h00;
            lo_q    <= 8'h00;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            c_q     <= c_d;
            z_q     <= z_d;
            v_q     <= v_d;
            n_q     <= n_d;
            ir_q    <= ir_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from the state register
    // -------------------------------------------------------------------------
    always_comb begin
        addr = pc_q;
        we   = 1'b0;
        sync = 1'b0;
        halt = 1'b0;
        case (state_q)
            ST_FETCH: sync = 1'b1;
            ST_MEM: begin
                addr = {hi_q, lo_q};
                // A stalled cycle repeats later, so it must not write now.
                we   = rdy && (ir_q == OP_STA_ABS);
            end
            ST_HALT: halt = 1'b1;
            default: ;
        endcase
    end

    assign d_out = a_q;
    assign a_out = a_q;
    assign p_out = {n_q, v_q, 1'b1, 3'b000, z_q, c_q};

endmodule

// File: tb/tb_acc_cpu.sv
// -----------------------------------------------------------------------------
// tb_acc_cpu -- self-checking bench for acc_cpu.
// dut0: ADDR_W=16, RESET_PC=0 with a 64 KiB memory.
// dut1: ADDR_W=9, RESET_PC=1FF with a 512 B memory (PC wrap).
// ALU behaviour comes from a vector table; stores go through a write
// scoreboard checked whenever the CPU strobes we.
// -----------------------------------------------------------------------------
module tb_acc_cpu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut0
    logic        rst0, rdy0;
    logic [7:0]  d_in0, d_out0, a_out0, p_out0;
    logic [15:0] addr0;
    logic        we0, sync0, halt0;
    logic [7:0]  mem0 [0:65535];

    // dut1
    logic        rst1, rdy1;
    logic [7:0]  d_in1, d_out1, a_out1, p_out1;
    logic [8:0]  addr1;
    logic        we1, sync1, halt1;
    logic [7:0]  mem1 [0:511];

    assign d_in0 = mem0[addr0];
    assign d_in1 = mem1[addr1];

    acc_cpu #(.ADDR_W(16), .RESET_PC(16'h0000)) dut0 (
        .clk(clk), .rst(rst0), .rdy(rdy0), .d_in(d_in0), .addr(addr0),
        .d_out(d_out0), .we(we0), .sync(sync0), .halt(halt0),
        .a_out(a_out0), .p_out(p_out0)
    );

    acc_cpu #(.ADDR_W(9), .RESET_PC(9'h1FF)) dut1 (
        .clk(clk), .rst(rst1), .rdy(rdy1), .d_in(d_in1), .addr(addr1),
        .d_out(d_out1), .we(we1), .sync(sync1), .halt(halt1),
        .a_out(a_out1), .p_out(p_out1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Write scoreboard
    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t wr_q[$];
    int  wr_seen;

    // Advance n clock edges. The write strobe is sampled at the falling edge;
    // the memory update is applied just after the rising edge.
    task automatic tick(input int n);
        logic        w_en;
        logic [15:0] w_a;
        logic [7:0]  w_d;
        wr_t         e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            w_en = we0 && !rst0;
            w_a  = addr0;
            w_d  = d_out0;
            if (w_en) begin
                wr_seen++;
                if (wr_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got write %0h to %0h, expected none", w_d, w_a);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_addr", 32'(w_a), 32'(e.a));
                    check("wr_data", 32'(w_d), 32'(e.d));
                end
            end
            if (we1 && !rst1) begin
                n_vec++;
                n_err++;
                $display("FAIL dut1_write: got we=1 at %0h, expected we=0", addr1);
            end
            @(posedge clk);
            #1;
            if (w_en) mem0[w_a] = w_d;
        end
    endtask

    task automatic reset0_begin();
        rst0    = 1'b1;
        rdy0    = 1'b1;
        wr_seen = 0;
        wr_q.delete();
        for (int i = 0; i < 65536; i++) mem0[i] = 8'hEA;
        #1;
    endtask

    task automatic reset0_end();
        tick(2);
        rst0 = 1'b0;
        #1;
    endtask

    task automatic writes_done(input string name, input int exp_cnt);
        check({name, "_wr_count"},   32'(wr_seen),     32'(exp_cnt));
        check({name, "_wr_pending"}, 32'(wr_q.size()), 32'd0);
    endtask

    // Vector table: program = (pre_c ? SEC : CLC), LDA #a0, op, opnd
    typedef struct {
        logic        pre_c;
        logic [7:0]  a0;
        logic [7:0]  op;
        logic [7:0]  opnd;
        logic [7:0]  exp_a;
        logic [7:0]  exp_p;
        logic [15:0] exp_pc;
    } vec_t;
    vec_t vecs[$];

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  p;
        logic [15:0] pc;
    } res_t;
    res_t exp_q[$];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        rst1 = 1'b1;
        rdy1 = 1'b1;
        for (int i = 0; i < 512; i++) mem1[i] = 8'h00;

        //                 pre_c a0     op     opnd   exp_a  exp_p  exp_pc
        vecs.push_back(vec_t'{1'b0, 8'h7F, 8'h69, 8'h01, 8'h80, 8'hE0, 16'd5});
        vecs.push_back(vec_t'{1'b1, 8'hFF, 8'h69, 8'h00, 8'h00, 8'h23, 16'd5});
        vecs.push_back(vec_t'{1'b0, 8'h80, 8'h69, 8'h80, 8'h00, 8'h63, 16'd5});
        vecs.push_back(vec_t'{1'b1, 8'h50, 8'h69, 8'h50, 8'hA1, 8'hE0, 16'd5});
        vecs.push_back(vec_t'{1'b1, 8'h00, 8'h69, 8'h00, 8'h01, 8'h20, 16'd5});
        vecs.push_back(vec_t'{1'b1, 8'h3F, 8'h69, 8'hC0, 8'h00, 8'h23, 16'd5});
        vecs.push_back(vec_t'{1'b1, 8'hF0, 8'h29, 8'h3C, 8'h30, 8'h21, 16'd5});
        vecs.push_back(vec_t'{1'b0, 8'h0F, 8'h29, 8'hF0, 8'h00, 8'h22, 16'd5});
        vecs.push_back(vec_t'{1'b0, 8'h80, 8'h09, 8'h01, 8'h81, 8'hA0, 16'd5});
        vecs.push_back(vec_t'{1'b0, 8'h00, 8'h09, 8'h00, 8'h00, 8'h22, 16'd5});
        vecs.push_back(vec_t'{1'b1, 8'hFF, 8'h49, 8'hFF, 8'h00, 8'h23, 16'd5});
        vecs.push_back(vec_t'{1'b0, 8'h55, 8'h49, 8'hAA, 8'hFF, 8'hA0, 16'd5});
        vecs.push_back(vec_t'{1'b0, 8'h80, 8'hA9, 8'h00, 8'h00, 8'h22, 16'd5});
        vecs.push_back(vec_t'{1'b0, 8'h00, 8'h38, 8'h00, 8'h00, 8'h23, 16'd4});
        vecs.push_back(vec_t'{1'b1, 8'h80, 8'h18, 8'h00, 8'h80, 8'hA0, 16'd4});
        vecs.push_back(vec_t'{1'b1, 8'h42, 8'hEA, 8'h00, 8'h42, 8'h21, 16'd4});

        // ---------------- table-driven ALU / flag vectors ----------------
        foreach (vecs[i]) begin
            reset0_begin();
            mem0[0] = vecs[i].pre_c ? 8'h38 : 8'h18;
            mem0[1] = 8'hA9;
            mem0[2] = vecs[i].a0;
            mem0[3] = vecs[i].op;
            mem0[4] = vecs[i].opnd;
            exp_q.push_back(res_t'{vecs[i].exp_a, vecs[i].exp_p, vecs[i].exp_pc});
            reset0_end();
            tick(6);
            r = exp_q.pop_front();
            check($sformatf("vec%0d_a",    i), 32'(a_out0), 32'(r.a));
            check($sformatf("vec%0d_p",    i), 32'(p_out0), 32'(r.p));
            check($sformatf("vec%0d_pc",   i), 32'(addr0),  32'(r.pc));
            check($sformatf("vec%0d_sync", i), 32'(sync0),  32'd1);
        end

        // ---------------- immediate sequence A9 7F 69 01 ----------------
        reset0_begin();
        mem0[0] = 8'hA9; mem0[1] = 8'h7F; mem0[2] = 8'h69; mem0[3] = 8'h01;
        reset0_end();
        tick(2);
        check("imm_lda_a", 32'(a_out0), 32'h7F);
        tick(2);
        check("imm_a",  32'(a_out0), 32'h80);
        check("imm_p",  32'(p_out0), 32'hE0);
        check("imm_pc", 32'(addr0),  32'h0004);

        // ---------------- absolute store / load ----------------
        reset0_begin();
        mem0[0] = 8'hA9; mem0[1] = 8'h55;
        mem0[2] = 8'h8D; mem0[3] = 8'h00; mem0[4] = 8'h02;
        mem0[5] = 8'hA9; mem0[6] = 8'h00;
        mem0[7] = 8'hAD; mem0[8] = 8'h00; mem0[9] = 8'h02;
        wr_q.push_back(wr_t'{16'h0200, 8'h55});
        reset0_end();
        tick(5);
        check("sta_mem_addr", 32'(addr0),  32'h0200);
        check("sta_mem_we",   32'(we0),    32'd1);
        check("sta_mem_dout", 32'(d_out0), 32'h55);
        tick(3);
        check("lda0_a", 32'(a_out0), 32'h00);
        tick(4);
        check("ldabs_a",    32'(a_out0), 32'h55);
        check("ldabs_p",    32'(p_out0), 32'h20);
        check("ldabs_pc",   32'(addr0),  32'h000A);
        check("ldabs_sync", 32'(sync0),  32'd1);
        writes_done("stld", 1);

        // ---------------- reset values with non-zero state ----------------
        rst0 = 1'b1;
        #1;
        check("rst_addr", 32'(addr0),  32'h0000);
        check("rst_we",   32'(we0),    32'd0);
        check("rst_sync", 32'(sync0),  32'd1);
        check("rst_halt", 32'(halt0),  32'd0);
        check("rst_a",    32'(a_out0), 32'h00);
        check("rst_p",    32'(p_out0), 32'h20);

        // ---------------- stall in MEM of STA ----------------
        reset0_begin();
        mem0[0] = 8'hA9; mem0[1] = 8'h55;
        mem0[2] = 8'h8D; mem0[3] = 8'h00; mem0[4] = 8'h02;
        mem0[5] = 8'hA9; mem0[6] = 8'h00;
        mem0[7] = 8'hAD; mem0[8] = 8'h00; mem0[9] = 8'h02;
        wr_q.push_back(wr_t'{16'h0200, 8'h55});
        reset0_end();
        tick(5);
        rdy0 = 1'b0;
        #1;
        check("stall_we0",   32'(we0),   32'd0);
        check("stall_addr0", 32'(addr0), 32'h0200);
        for (int s = 1; s <= 3; s++) begin
            tick(1);
            check($sformatf("stall%0d_we",   s), 32'(we0),   32'd0);
            check($sformatf("stall%0d_addr", s), 32'(addr0), 32'h0200);
        end
        rdy0 = 1'b1;
        #1;
        check("stall_resume_we",   32'(we0),    32'd1);
        check("stall_resume_addr", 32'(addr0),  32'h0200);
        tick(7);
        check("stall_end_pc",   32'(addr0),  32'h000A);
        check("stall_end_sync", 32'(sync0),  32'd1);
        check("stall_end_a",    32'(a_out0), 32'h55);
        writes_done("stall", 1);

        // ---------------- JMP abs ----------------
        reset0_begin();
        mem0[0] = 8'h4C; mem0[1] = 8'h34; mem0[2] = 8'h12;
        reset0_end();
        tick(2);
        check("jmp_op2_sync", 32'(sync0), 32'd0);
        check("jmp_op2_addr", 32'(addr0), 32'h0002);
        tick(1);
        check("jmp_addr", 32'(addr0), 32'h1234);
        check("jmp_sync", 32'(sync0), 32'd1);
        tick(2);
        check("jmp_nop_addr", 32'(addr0), 32'h1235);

        // ---------------- undefined opcode ----------------
        reset0_begin();
        mem0[0] = 8'hFF;
        reset0_end();
        check("bad_pre_halt", 32'(halt0), 32'd0);
        tick(1);
        check("bad_halt", 32'(halt0), 32'd1);
        check("bad_sync", 32'(sync0), 32'd0);
        check("bad_addr", 32'(addr0), 32'h0001);
        tick(5);
        check("bad_hold_halt", 32'(halt0), 32'd1);
        check("bad_hold_addr", 32'(addr0), 32'h0001);
        check("bad_hold_we",   32'(we0),   32'd0);
        writes_done("bad", 0);
        rst0 = 1'b1;
        #1;
        check("bad_rst_halt", 32'(halt0), 32'd0);
        check("bad_rst_addr", 32'(addr0), 32'h0000);

        // ---------------- reset during OP2 of STA ----------------
        reset0_begin();
        mem0[0] = 8'hA9; mem0[1] = 8'h55;
        mem0[2] = 8'h8D; mem0[3] = 8'h00; mem0[4] = 8'h02;
        reset0_end();
        tick(4);
        check("mid_op2_addr", 32'(addr0),  32'h0004);
        check("mid_op2_a",    32'(a_out0), 32'h55);
        rst0 = 1'b1;
        #1;
        check("mid_rst_a",    32'(a_out0), 32'h00);
        check("mid_rst_p",    32'(p_out0), 32'h20);
        check("mid_rst_addr", 32'(addr0),  32'h0000);
        check("mid_rst_sync", 32'(sync0),  32'd1);
        tick(2);
        rst0 = 1'b0;
        #1;
        check("mid_restart_addr", 32'(addr0), 32'h0000);
        tick(2);
        check("mid_restart_a",  32'(a_out0), 32'h55);
        check("mid_restart_pc", 32'(addr0),  32'h0002);
        writes_done("mid", 0);
        rst0 = 1'b1;
        #1;

        // ---------------- ADDR_W=9 PC wrap ----------------
        mem1[9'h1FF] = 8'hEA;
        mem1[9'h000] = 8'hEA;
        #1;
        check("w_rst_addr", 32'(addr1),  32'h1FF);
        check("w_rst_sync", 32'(sync1),  32'd1);
        check("w_rst_p",    32'(p_out1), 32'h20);
        tick(1);
        rst1 = 1'b0;
        #1;
        tick(1);
        check("w_impl_addr", 32'(addr1), 32'h000);
        check("w_impl_sync", 32'(sync1), 32'd0);
        tick(1);
        check("w_fetch_addr", 32'(addr1), 32'h000);
        check("w_fetch_sync", 32'(sync1), 32'd1);
        check("w_halt",       32'(halt1), 32'd0);
        rst1 = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/acc_cpu.md
ACC_CPU -- requirements
Module: acc_cpu

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address bus width, legal range 9..16.
REQ-002 SHALL have parameter RESET_PC, default 0, value loaded into PC on reset, ADDR_W bits.
REQ-003 SHALL have port clk  input  1  single clock, all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port rdy  input  1  1 = advance, 0 = stall current cycle.
REQ-006 SHALL have port d_in  input  8  read data from memory, combinational response to addr in the same cycle.
REQ-007 SHALL have port addr  output  ADDR_W  memory address.
REQ-008 SHALL have port d_out  output  8  write data, meaningful only while we=1.
REQ-009 SHALL have port we  output  1  memory write strobe; memory captures d_out at addr on a rising clk edge while we=1.
REQ-010 SHALL have port sync  output  1  high during opcode-fetch cycles.
REQ-011 SHALL have port halt  output  1  high once an undefined opcode is fetched.
REQ-012 SHALL have port a_out  output  8  accumulator contents.
REQ-013 SHALL have port p_out  output  8  status byte {N,V,1,0,0,0,Z,C}.

Function
REQ-014 SHALL have states FETCH, OP1, OP2, MEM, IMPL, HALT, with all outputs decoded from the state register (Moore).
REQ-015 SHALL, in FETCH: addr=PC, sync=1, latch opcode from d_in, PC+1; go to OP1 for immediate and absolute opcodes, IMPL for implied opcodes, HALT for any other opcode.
REQ-016 SHALL support opcodes LDA# A9, ADC# 69, AND# 29, ORA# 09, EOR# 49, LDA abs AD, STA abs 8D, JMP abs 4C, CLC 18, SEC 38, NOP EA.
REQ-017 SHALL, in OP1: addr=PC, PC+1; immediate opcodes execute on d_in then go to FETCH; absolute opcodes latch the low address byte then go to OP2.
REQ-018 SHALL, in OP2: addr=PC, latch the high address byte, PC+1; JMP loads PC={hi,lo}[ADDR_W-1:0] instead of incrementing and goes to FETCH; LDA and STA go to MEM.
REQ-019 SHALL, in MEM: addr={hi,lo}[ADDR_W-1:0]; LDA loads A from d_in; STA drives we=1 and d_out=A; then go to FETCH.
REQ-020 SHALL, in IMPL: addr=PC with no PC change; CLC sets C=0, SEC sets C=1, NOP changes nothing; then go to FETCH.
REQ-021 SHALL take 2 cycles for immediate and implied, 3 for JMP, and 4 for LDA and STA absolute.
REQ-022 SHALL compute ADC as {C,A} = A + operand + C (9-bit), with V = (A[7]==op[7]) && (sum[7]!=A[7]).
REQ-023 SHALL update Z=(result==0) and N=result[7] on LDA, ADC, AND, ORA and EOR; STA, JMP and NOP leave all flags unchanged.
REQ-024 SHALL wrap PC modulo 2^ADDR_W, so PC at all-ones increments to 0.
REQ-025 SHALL, when rdy=0, hold state, PC, A, P and latches, hold addr, and force we=0; the cycle resumes unchanged when rdy returns to 1.
REQ-026 SHALL, in HALT: assert halt=1, keep we=0 and sync=0, hold addr=PC, and remain in HALT until reset.
REQ-027 SHALL drive d_out=A at all times; d_out is qualified only by we.

Reset
REQ-028 SHALL, on rst=1 at any time including mid-instruction, immediately set state=FETCH, PC=RESET_PC, A=0, C=Z=V=N=0, and clear the opcode and address latches.
REQ-029 SHALL hold outputs during reset at addr=RESET_PC, we=0, sync=1, halt=0, a_out=0, p_out=8'h20.
REQ-030 SHALL fetch the first opcode from RESET_PC on the first rising edge after rst deasserts.

Verification
REQ-031 SHALL check immediate ALU sequence: program A9 7F, 69 01 at 0 -> after 4 cycles A=80, V=1, N=1, Z=0, C=0, PC=4.
REQ-032 SHALL check absolute store/load: A9 55, 8D 00 02, A9 00, AD 00 02 -> we=1 exactly once at addr 0200 with d_out=55, then A=55, Z=0; total 12 cycles.
REQ-033 SHALL check jump and wrap: ADDR_W=9, RESET_PC=1FF with byte EA at 1FF -> NOP executes and next fetch is at addr 000; separately 4C 34 12 with ADDR_W=16 -> next sync at addr 1234 on cycle 4.
REQ-034 SHALL check stall: rdy=0 for 3 cycles during MEM of STA -> we=0 throughout the stall, addr held, we=1 for a single cycle after rdy=1, total cycle count +3.
REQ-035 SHALL check undefined opcode: FF fetched -> halt=1 from the next cycle, no further address change or we, cleared only by rst.
REQ-036 SHALL check reset mid-instruction: assert rst during OP2 of 8D -> no write occurs, A=0, and the fetch restarts at RESET_PC.
